// File: rtl/ps_packet_gen_pkg.sv
// ps_packet_gen_pkg
// Shared definitions for the PacketStream packet generator: the FSM state
// encoding and the counting-payload function. Checkers can import this
// package so that they compute word data the same way the generator does.
package ps_packet_gen_pkg;

  // Generator states: waiting for a start, streaming words, idling between packets
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Word payload is packet index plus word index; the caller truncates the
  // result to the stream width, which gives the modulo wrap for free
  function automatic logic [31:0] ps_payload(input logic [15:0] p, input logic [31:0] w);
    return {16'd0, p} + w;
  endfunction

endpackage

// File: rtl/ps_packet_gen.sv
// ps_packet_gen
// Packet-level PacketStream source. After a start request it emits a
// configurable number of fixed-length packets (or runs forever), optionally
// separated by idle gap cycles. Word data is (packet index + word index).
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   ctl_start  single-cycle start request (ignored unless idle and ctl_len != 0)
//   ctl_len    words per packet
//   ctl_gap    idle cycles between packets
//   ctl_count  packets to send, 0 = continuous
//   ctl_stop   single-cycle graceful stop request
//   ctl_busy   high whenever the generator is not idle
//   stat_pkts  number of packets whose eop word was accepted this run
//   o_dat      stream data
//   o_val      word valid
//   o_eop      last word of packet
//   o_rdy      downstream ready
module ps_packet_gen
  import ps_packet_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LENW  = 16,
  parameter int GAPW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctl_start,
  input  logic [LENW-1:0]  ctl_len,
  input  logic [GAPW-1:0]  ctl_gap,
  input  logic [15:0]      ctl_count,
  input  logic             ctl_stop,
  output logic             ctl_busy,
  output logic [31:0]      stat_pkts,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_val,
  output logic             o_eop,
  input  logic             o_rdy
);

  state_e           state_q;
  logic [LENW-1:0]  len_q;
  logic [LENW-1:0]  w_q;
  logic [GAPW-1:0]  gap_q;
  logic [GAPW-1:0]  gapCnt_q;
  logic [15:0]      count_q;
  logic [15:0]      p_q;
  logic             stop_q;
  logic [31:0]      pkts_q;
  logic [WIDTH-1:0] dat_q;
  logic             val_q;
  logic             eop_q;

  logic [LENW-1:0]  wNext_d;
  logic [15:0]      pNext_d;
  logic             stopSet_d;
  logic             done_d;
  logic             wNextLast_d;
  logic             firstLast_d;

  // Next-index helpers and the end-of-run decision shared by SEND and GAP.
  // A stop arriving in the same cycle as the eop acceptance counts as pending.
  always_comb begin
    wNext_d     = w_q + LENW'(1);
    pNext_d     = p_q + 16'd1;
    stopSet_d   = stop_q | ctl_stop;
    done_d      = stopSet_d | ((count_q != 16'd0) && (pNext_d == count_q));
    wNextLast_d = (wNext_d == (len_q - LENW'(1)));
    firstLast_d = (len_q == LENW'(1));
  end

  // Single FSM with registered outputs. The output word register only
  // advances when it is empty or being accepted, so data and eop hold
  // under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      w_q      <= '0;
      gap_q    <= '0;
      gapCnt_q <= '0;
      count_q  <= '0;
      p_q      <= '0;
      stop_q   <= 1'b0;
      pkts_q   <= '0;
      dat_q    <= '0;
      val_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ctl_start && (ctl_len != '0)) begin
            len_q   <= ctl_len;
            gap_q   <= ctl_gap;
            count_q <= ctl_count;
            pkts_q  <= '0;
            p_q     <= '0;
            w_q     <= '0;
            stop_q  <= 1'b0;
            val_q   <= 1'b1;
            dat_q   <= '0;
            eop_q   <= (ctl_len == LENW'(1));
            state_q <= SEND;
          end
        end

        SEND: begin
          if (ctl_stop) begin
            stop_q <= 1'b1;
          end
          if (o_rdy) begin
            if (!eop_q) begin
              w_q   <= wNext_d;
              dat_q <= WIDTH'(ps_payload(p_q, 32'(wNext_d)));
              eop_q <= wNextLast_d;
            end else begin
              pkts_q <= pkts_q + 32'd1;
              p_q    <= pNext_d;
              w_q    <= '0;
              if (done_d) begin
                state_q <= IDLE;
                val_q   <= 1'b0;
                eop_q   <= 1'b0;
                stop_q  <= 1'b0;
              end else if (gap_q == '0) begin
                dat_q <= WIDTH'(ps_payload(pNext_d, 32'd0));
                eop_q <= firstLast_d;
              end else begin
                state_q  <= GAP;
                val_q    <= 1'b0;
                eop_q    <= 1'b0;
                gapCnt_q <= gap_q;
              end
            end
          end
        end

        GAP: begin
          if (stopSet_d) begin
            state_q <= IDLE;
            stop_q  <= 1'b0;
          end else if (gapCnt_q == GAPW'(1)) begin
            state_q <= SEND;
            val_q   <= 1'b1;
            dat_q   <= WIDTH'(ps_payload(p_q, 32'd0));
            eop_q   <= firstLast_d;
          end else begin
            gapCnt_q <= gapCnt_q - GAPW'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ctl_busy  = (state_q != IDLE);
  assign stat_pkts = pkts_q;
  assign o_dat     = dat_q;
  assign o_val     = val_q;
  assign o_eop     = eop_q;

endmodule

// File: tb/tb_ps_packet_gen.sv
// tb_ps_packet_gen
// Self-checking bench for ps_packet_gen. Directed stimulus pushes the
// expected words into a scoreboard queue; a monitor process pops and
// compares every accepted word, and also checks hold behaviour under
// backpressure and measures gaps between packets.
module tb_ps_packet_gen;

  typedef struct {
    logic [7:0] dat;
    logic       eop;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ctl_start;
  logic [15:0] ctl_len;
  logic [7:0]  ctl_gap;
  logic [15:0] ctl_count;
  logic        ctl_stop;
  logic        ctl_busy;
  logic [31:0] stat_pkts;
  logic [7:0]  o_dat;
  logic        o_val;
  logic        o_eop;
  logic        o_rdy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t expQ[$];
  int   gapQ[$];
  int   valCount;
  int   firstCyc;
  int   lastCyc;
  int   lastEopCyc;
  int   idleRun;
  bit   seenWord;
  int   idleCyc;
  bit   rndRdy = 1'b0;

  ps_packet_gen dut (
    .clk       (clk),
    .reset     (reset),
    .ctl_start (ctl_start),
    .ctl_len   (ctl_len),
    .ctl_gap   (ctl_gap),
    .ctl_count (ctl_count),
    .ctl_stop  (ctl_stop),
    .ctl_busy  (ctl_busy),
    .stat_pkts (stat_pkts),
    .o_dat     (o_dat),
    .o_val     (o_val),
    .o_eop     (o_eop),
    .o_rdy     (o_rdy)
  );

  // Free-running clock and a cycle counter used for latency and span checks
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Downstream ready: held high unless the backpressure test enables random stalls
  initial begin
    o_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      o_rdy = rndRdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Hard stop in case something hangs beyond every bounded wait
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge
  initial begin
    exp_t       e;
    bit         held = 1'b0;
    logic [7:0] heldDat = '0;
    logic       heldEop = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          checkOutput("hold_val", 32'(o_val), 32'd1);
          checkOutput("hold_dat", 32'(o_dat), 32'(heldDat));
          checkOutput("hold_eop", 32'(o_eop), 32'(heldEop));
        end
        if (o_val) begin
          valCount = valCount + 1;
          if (firstCyc < 0) firstCyc = cyc;
          lastCyc = cyc;
          if (seenWord && idleRun > 0) gapQ.push_back(idleRun);
          idleRun  = 0;
          seenWord = 1'b1;
          if (o_rdy) begin
            held = 1'b0;
            if (o_eop) lastEopCyc = cyc;
            if (expQ.size() == 0) begin
              checks = checks + 1;
              errors = errors + 1;
              $display("[TB] FAIL unexpected_word: got dat %0h eop %0b, expected no word", o_dat, o_eop);
            end else begin
              e = expQ.pop_front();
              checkOutput("word_dat", 32'(o_dat), 32'(e.dat));
              checkOutput("word_eop", 32'(o_eop), 32'(e.eop));
            end
          end else begin
            held    = 1'b1;
            heldDat = o_dat;
            heldEop = o_eop;
          end
        end else begin
          held    = 1'b0;
          idleRun = idleRun + 1;
        end
      end
    end
  end

  task automatic clearTrace();
    expQ.delete();
    gapQ.delete();
    valCount   = 0;
    firstCyc   = -1;
    lastCyc    = -1;
    lastEopCyc = -1;
    idleRun    = 0;
    seenWord   = 1'b0;
  endtask

  task automatic pushWord(input logic [7:0] d, input logic e);
    exp_t x;
    x.dat = d;
    x.eop = e;
    expQ.push_back(x);
  endtask

  task automatic pushPacket(input int p, input int len);
    for (int w = 0; w < len; w++) begin
      pushWord(8'((p + w) & 255), (w == len - 1));
    end
  endtask

  // One-cycle start pulse; returns one cycle after the start was sampled
  task automatic applyStimulus(input logic [15:0] len, input logic [7:0] gap, input logic [15:0] count);
    @(posedge clk);
    #1;
    ctl_start = 1'b1;
    ctl_len   = len;
    ctl_gap   = gap;
    ctl_count = count;
    @(posedge clk);
    #1;
    ctl_start = 1'b0;
  endtask

  task automatic waitIdle(input int maxCyc);
    int n = 0;
    while (ctl_busy === 1'b1 && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", 32'(ctl_busy), 32'd0);
    idleCyc = cyc;
  endtask

  initial begin
    bit found;
    reset     = 1'b0;
    ctl_start = 1'b0;
    ctl_len   = '0;
    ctl_gap   = '0;
    ctl_count = '0;
    ctl_stop  = 1'b0;
    clearTrace();

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_val", 32'(o_val), 32'd0);
    checkOutput("reset_eop", 32'(o_eop), 32'd0);
    checkOutput("reset_dat", 32'(o_dat), 32'd0);
    checkOutput("reset_busy", 32'(ctl_busy), 32'd0);
    checkOutput("reset_pkts", stat_pkts, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic run: len 4, gap 0, count 2
    clearTrace();
    pushWord(8'd0, 1'b0); pushWord(8'd1, 1'b0); pushWord(8'd2, 1'b0); pushWord(8'd3, 1'b1);
    pushWord(8'd1, 1'b0); pushWord(8'd2, 1'b0); pushWord(8'd3, 1'b0); pushWord(8'd4, 1'b1);
    applyStimulus(16'd4, 8'd0, 16'd2);
    checkOutput("start_busy", 32'(ctl_busy), 32'd1);
    checkOutput("start_val", 32'(o_val), 32'd1);
    waitIdle(100);
    checkOutput("basic_pkts", stat_pkts, 32'd2);
    checkOutput("basic_words", 32'(valCount), 32'd8);
    checkOutput("basic_span", 32'(lastCyc - firstCyc + 1), 32'd8);
    checkOutput("basic_idle_latency", 32'(idleCyc - lastEopCyc), 32'd1);
    checkOutput("basic_queue", 32'(expQ.size()), 32'd0);

    // Gap: len 3, gap 5, count 3
    clearTrace();
    for (int p = 0; p < 3; p++) pushPacket(p, 3);
    applyStimulus(16'd3, 8'd5, 16'd3);
    waitIdle(200);
    checkOutput("gap_pkts", stat_pkts, 32'd3);
    checkOutput("gap_span", 32'(lastCyc - firstCyc + 1), 32'd19);
    checkOutput("gap_count", 32'(gapQ.size()), 32'd2);
    for (int i = 0; i < gapQ.size(); i++) checkOutput("gap_len", 32'(gapQ[i]), 32'd5);
    checkOutput("gap_queue", 32'(expQ.size()), 32'd0);

    // Backpressure: len 6, gap 2, count 3, random ready
    clearTrace();
    for (int p = 0; p < 3; p++) pushPacket(p, 6);
    rndRdy = 1'b1;
    applyStimulus(16'd6, 8'd2, 16'd3);
    waitIdle(1000);
    rndRdy = 1'b0;
    checkOutput("bp_pkts", stat_pkts, 32'd3);
    checkOutput("bp_queue", 32'(expQ.size()), 32'd0);

    // Stop: continuous, len 8, gap 2; stop during word 3 of packet p=4
    clearTrace();
    for (int p = 0; p < 5; p++) pushPacket(p, 8);
    applyStimulus(16'd8, 8'd2, 16'd0);
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(posedge clk);
      #1;
      if (o_val && stat_pkts == 32'd4 && o_dat == 8'd7) found = 1'b1;
    end
    checkOutput("stop_found_word", 32'(found), 32'd1);
    ctl_stop = 1'b1;
    @(posedge clk);
    #1;
    ctl_stop = 1'b0;
    waitIdle(200);
    repeat (4) @(negedge clk);
    checkOutput("stop_pkts", stat_pkts, 32'd5);
    checkOutput("stop_queue", 32'(expQ.size()), 32'd0);

    // Zero-length start is ignored and the packet count holds
    clearTrace();
    applyStimulus(16'd0, 8'd0, 16'd1);
    checkOutput("len0_busy", 32'(ctl_busy), 32'd0);
    checkOutput("len0_val", 32'(o_val), 32'd0);
    checkOutput("len0_pkts", stat_pkts, 32'd5);

    // Start while busy does not disturb the stream
    clearTrace();
    pushPacket(0, 4);
    pushPacket(1, 4);
    applyStimulus(16'd4, 8'd0, 16'd2);
    @(posedge clk);
    #1;
    ctl_start = 1'b1;
    ctl_len   = 16'd7;
    ctl_gap   = 8'd3;
    ctl_count = 16'd5;
    @(posedge clk);
    #1;
    ctl_start = 1'b0;
    waitIdle(100);
    checkOutput("busy_start_pkts", stat_pkts, 32'd2);
    checkOutput("busy_start_queue", 32'(expQ.size()), 32'd0);

    // Stop coincident with eop acceptance, gap 0, continuous
    clearTrace();
    pushPacket(0, 3);
    applyStimulus(16'd3, 8'd0, 16'd0);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (o_val && o_eop) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("eopstop_found", 32'(found), 32'd1);
    ctl_stop = 1'b1;
    @(posedge clk);
    #1;
    ctl_stop = 1'b0;
    checkOutput("eopstop_busy", 32'(ctl_busy), 32'd0);
    checkOutput("eopstop_val", 32'(o_val), 32'd0);
    waitIdle(50);
    repeat (3) @(negedge clk);
    checkOutput("eopstop_pkts", stat_pkts, 32'd1);
    checkOutput("eopstop_queue", 32'(expQ.size()), 32'd0);

    // Reset mid-packet at word 2 of a length-5 packet
    clearTrace();
    pushWord(8'd0, 1'b0);
    pushWord(8'd1, 1'b0);
    applyStimulus(16'd5, 8'd0, 16'd1);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (o_val && o_dat == 8'd2) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("rst_found_word", 32'(found), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rst_val", 32'(o_val), 32'd0);
    checkOutput("rst_eop", 32'(o_eop), 32'd0);
    checkOutput("rst_busy", 32'(ctl_busy), 32'd0);
    checkOutput("rst_pkts", stat_pkts, 32'd0);
    checkOutput("rst_queue", 32'(expQ.size()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clearTrace();
    pushPacket(0, 5);
    applyStimulus(16'd5, 8'd0, 16'd1);
    waitIdle(50);
    checkOutput("rst_restart_pkts", stat_pkts, 32'd1);
    checkOutput("rst_restart_queue", 32'(expQ.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps_packet_gen.md
# ps_packet_gen

Packet-level source for the PacketStream interface. It emits a configurable number of fixed-length packets, separated by an optional idle gap. Each word carries a deterministic counting payload. The block drives the output side of the val/eop/rdy handshake and is the stimulus source for link bring-up, loopback checks and throughput measurement.

## Interface
- WIDTH, 8: stream data width.
- LENW, 16: width of the packet-length field.
- GAPW, 8: width of the inter-packet gap field.
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronous to clk.
- ctl_start  input  1  single-cycle start request.
- ctl_len  input  LENW  words per packet. 0 is illegal and the request is ignored.
- ctl_gap  input  GAPW  idle cycles between packets.
- ctl_count  input  16  number of packets to send. 0 means continuous.
- ctl_stop  input  1  single-cycle graceful stop request.
- ctl_busy  output  1  high in any state other than IDLE.
- stat_pkts  output  32  count of completed packets (eop accepted).
- o_dat  output  WIDTH  stream data.
- o_val  output  1  word valid.
- o_eop  output  1  last word of the packet.
- o_rdy  input  1  downstream ready.

## Operation
- States: IDLE, SEND, GAP.
- IDLE, ctl_start=1 and ctl_len≠0:
  - latch len, gap and count;
  - clear stat_pkts, packet index p and word index w;
  - go to SEND.
- IDLE, ctl_start=1 and ctl_len=0: no effect.
- ctl_start outside IDLE: ignored. Latched configuration does not change during a run.
- Payload: o_dat = (p + w) mod 2^WIDTH, with w = 0..len-1. o_eop=1 exactly when w = len-1.
- A word is accepted on o_val & o_rdy. While o_val=1 and o_rdy=0, o_dat and o_eop hold.
- SEND, non-last word accepted: w increments; the next word is presented in the next cycle.
- SEND, eop word accepted:
  - stat_pkts increments;
  - p increments (wraps at 2^16);
  - w resets to 0.
  - Then, in priority order:
    - stop pending, or count≠0 and p+1 = count: go to IDLE;
    - gap=0: stay in SEND; the next packet's first word is presented in the next cycle (back-to-back);
    - otherwise: go to GAP.
- GAP: o_val=0 for exactly gap cycles, then SEND.
- ctl_stop in SEND or GAP sets stop pending.
  - A packet already started is never truncated.
  - Stop pending in GAP: go directly to IDLE without starting a new packet.
  - Stop pending is cleared on entry to IDLE.
  - ctl_stop in IDLE has no effect.
- Simultaneous ctl_stop and eop acceptance: treated as stop pending, so the block ends in IDLE after that packet.
- stat_pkts wraps at 2^32. It holds its value after the run until the next accepted start.

## Timing
- Reset values: o_val=0, o_eop=0, o_dat=0, ctl_busy=0, stat_pkts=0, state IDLE, stop pending 0.
- All outputs are registered. There is no combinational path from o_rdy or any ctl_* input to any output.
- Start latency: ctl_start sampled in cycle N; ctl_busy=1 and first word valid in cycle N+1.
- Throughput: 1 word per cycle while o_rdy=1.
- With o_rdy held at 1, each packet occupies len+gap cycles.
- Return to idle: last eop accepted in cycle M; o_val=0 and ctl_busy=0 in cycle M+1.
- Reset mid-packet: outputs return to reset values immediately (asynchronously). No eop is emitted for the partial packet.

## Structure
- Shared package ps_packet_gen_pkg holds:
  - the state enum (IDLE, SEND, GAP);
  - the payload function (p, w) → o_dat, so that checkers reuse it.
- No sub-module.
  - The output stage is a single registered stage that loads on ~o_val | o_rdy.
  - Downstream timing isolation is the integrator's responsibility.

## Test plan
- Basic run: len=4, gap=0, count=2, o_rdy=1.
  - Required: 8 contiguous words, data 0,1,2,3 then 1,2,3,4.
  - o_eop high on the 4th and 8th words.
  - stat_pkts=2; ctl_busy falls one cycle after the last eop.
- Gap: len=3, gap=5, count=3.
  - Required: exactly 5 o_val=0 cycles between packets.
  - Total active span is 3·3 + 2·5 = 19 cycles.
- Backpressure: len=6, random o_rdy at 50% duty.
  - Required: o_dat and o_eop stable whenever o_val & ~o_rdy.
  - Sequence matches the o_rdy=1 reference; no words lost or duplicated.
- Stop: count=0, len=8; ctl_stop pulsed during word 3 of packet 5 (p=4).
  - Required: packet p=4 completes with eop; no further o_val.
  - stat_pkts=5.
- Edge requests:
  - ctl_len=0 start: ctl_busy stays 0.
  - ctl_start while busy: no change in the stream.
  - ctl_stop on the eop-accept cycle with gap=0: IDLE, no new packet.
- Reset mid-packet: assert reset at word 2 of len=5.
  - Required: o_val=0 immediately and stat_pkts=0.
  - After release, a new start reproduces data 0..4.
